// File: rtl/flash_read_controller.sv
// Avalon-MM read initiator feeding 32-bit flash words to the audio path one
// 16-bit half at a time. A new word is fetched only after both halves of the
// current word have been consumed; playback can run forwards or backwards and
// can be rewound to the start of the sample region.
module flash_read_controller #(
  parameter int                ADDR_W   = 23,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] END_ADDR = 23'h7FFFF
) (
  input  logic              fast_clock,
  input  logic              reset,
  input  logic              sample_req,
  input  logic              enable,
  input  logic              direction,
  input  logic              restart,
  output logic              flash_mem_read,
  output logic [ADDR_W-1:0] flash_mem_address,
  input  logic              flash_mem_waitrequest,
  input  logic              flash_mem_readdatavalid,
  input  logic [DATA_W-1:0] flash_mem_readdata,
  output logic [DATA_W-1:0] read_data,
  output logic              data_valid,
  output logic              data_bus_select,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic              half_left, half_left_nxt;
  logic              dir_q, dir_nxt;
  logic              pend, pend_nxt;
  logic              rst_pend, rst_pend_nxt;
  logic              read_nxt;
  logic [ADDR_W-1:0] address_nxt;
  logic [DATA_W-1:0] read_data_nxt;
  logic              data_valid_nxt;
  logic              select_nxt;

  logic              req;
  logic              accept;
  logic [ADDR_W-1:0] rewind_addr;
  logic [ADDR_W-1:0] step_addr;

  // A queued request counts as a request in IDLE unless a restart discards it.
  assign req         = sample_req & enable;
  assign accept      = req | (pend & ~restart);
  assign rewind_addr = direction ? END_ADDR : '0;
  assign step_addr   = direction ? ((addr == '0) ? END_ADDR : addr - ADDR_W'(1))
                                 : ((addr == END_ADDR) ? '0 : addr + ADDR_W'(1));
  assign busy        = (state != IDLE);

  // Next-state and next-output decode for the fetch FSM.
  always_comb begin
    state_nxt      = state;
    addr_nxt       = addr;
    half_left_nxt  = half_left;
    dir_nxt        = dir_q;
    pend_nxt       = pend;
    rst_pend_nxt   = rst_pend;
    read_nxt       = flash_mem_read;
    address_nxt    = flash_mem_address;
    read_data_nxt  = read_data;
    data_valid_nxt = 1'b0;
    select_nxt     = data_bus_select;

    // While a read is in flight, a restart is deferred and wipes any queued
    // request; otherwise one extra request may be queued.
    if (state != IDLE) begin
      if (restart) begin
        rst_pend_nxt = 1'b1;
        pend_nxt     = 1'b0;
      end else if (req) begin
        pend_nxt = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        // Any queued request is either served now or discarded by restart.
        pend_nxt = 1'b0;
        if (restart) begin
          addr_nxt      = rewind_addr;
          half_left_nxt = 1'b0;
        end
        if (accept) begin
          if (half_left && !restart) begin
            select_nxt    = ~dir_q;
            half_left_nxt = 1'b0;
          end else begin
            state_nxt   = ISSUE;
            read_nxt    = 1'b1;
            address_nxt = restart ? rewind_addr : addr;
          end
        end
      end
      ISSUE: begin
        if (!flash_mem_waitrequest) begin
          read_nxt  = 1'b0;
          state_nxt = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (flash_mem_readdatavalid) begin
          read_data_nxt  = flash_mem_readdata;
          data_valid_nxt = 1'b1;
          dir_nxt        = direction;
          select_nxt     = direction;
          state_nxt      = IDLE;
          if (rst_pend || restart) begin
            addr_nxt      = rewind_addr;
            half_left_nxt = 1'b0;
            rst_pend_nxt  = 1'b0;
          end else begin
            addr_nxt      = step_addr;
            half_left_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset abandons any outstanding read.
  always_ff @(posedge fast_clock) begin
    if (reset) begin
      state             <= IDLE;
      addr              <= '0;
      half_left         <= 1'b0;
      dir_q             <= 1'b0;
      pend              <= 1'b0;
      rst_pend          <= 1'b0;
      flash_mem_read    <= 1'b0;
      flash_mem_address <= '0;
      read_data         <= '0;
      data_valid        <= 1'b0;
      data_bus_select   <= 1'b0;
    end else begin
      state             <= state_nxt;
      addr              <= addr_nxt;
      half_left         <= half_left_nxt;
      dir_q             <= dir_nxt;
      pend              <= pend_nxt;
      rst_pend          <= rst_pend_nxt;
      flash_mem_read    <= read_nxt;
      flash_mem_address <= address_nxt;
      read_data         <= read_data_nxt;
      data_valid        <= data_valid_nxt;
      data_bus_select   <= select_nxt;
    end
  end

endmodule
